// File: rtl/command_packetizer.sv
// Parses framed host bytes into single-cycle register writes; optional checksum byte under CMD_CHECKSUM_EN.
// Strobe is registered on the edge that accepts the last frame byte; no backpressure, every valid byte is consumed.
module command_packetizer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic [15:0] cmd_addr_o,
  output logic [31:0] cmd_data_o,
  output logic        cmd_valid_o,
  output logic        busy_o,
  output logic [7:0]  csum_err_cnt_o,
  output logic [7:0]  timeout_cnt_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef CMD_CHECKSUM_EN
  localparam int SH_W = 48;
  typedef enum logic [2:0] {IDLE, A_HI, A_LO, D3, D2, D1, D0, CSUM} state_t;
`else
  localparam int SH_W = 40;
  typedef enum logic [2:0] {IDLE, A_HI, A_LO, D3, D2, D1, D0} state_t;
`endif

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [15:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic [7:0]        to_cnt_q, to_cnt_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
  logic [7:0]        cerr_q, cerr_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idle_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      to_cnt_q <= '0;
`ifdef CMD_CHECKSUM_EN
      xor_q    <= '0;
      cerr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idle_q   <= idle_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      to_cnt_q <= to_cnt_d;
`ifdef CMD_CHECKSUM_EN
      xor_q    <= xor_d;
      cerr_q   <= cerr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idle_d   = idle_q;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    to_cnt_d = to_cnt_q;
`ifdef CMD_CHECKSUM_EN
    xor_d    = xor_q;
    cerr_d   = cerr_q;
`endif

    if (state_q == IDLE) begin
      idle_d = '0;
      if (byte_valid_i && byte_i == SYNC_BYTE) begin
        state_d  = A_HI;
        shadow_d = '0;
`ifdef CMD_CHECKSUM_EN
        xor_d    = '0;
`endif
      end
    end else if (byte_valid_i) begin
      // An arriving byte always beats the timeout, even on the last idle cycle.
      idle_d = '0;
`ifdef CMD_CHECKSUM_EN
      if (state_q != CSUM) begin
        shadow_d = {shadow_q[SH_W-9:0], byte_i};
        xor_d    = xor_q ^ byte_i;
      end
`else
      shadow_d = {shadow_q[SH_W-9:0], byte_i};
`endif
      case (state_q)
        A_HI: state_d = A_LO;
        A_LO: state_d = D3;
        D3:   state_d = D2;
        D2:   state_d = D1;
        D1:   state_d = D0;
`ifdef CMD_CHECKSUM_EN
        D0:   state_d = CSUM;
        CSUM: begin
          state_d = IDLE;
          if (byte_i == xor_q) begin
            addr_d  = shadow_q[47:32];
            data_d  = shadow_q[31:0];
            valid_d = 1'b1;
          end else if (cerr_q != 8'hFF) begin
            cerr_d = cerr_q + 8'd1;
          end
        end
`else
        D0: begin
          // Final data byte is still on the input, not yet in the shadow.
          state_d = IDLE;
          addr_d  = shadow_q[39:24];
          data_d  = {shadow_q[23:0], byte_i};
          valid_d = 1'b1;
        end
`endif
        default: state_d = IDLE;
      endcase
    end else if (idle_q == IDLE_LAST) begin
      state_d = IDLE;
      idle_d  = '0;
      if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
    end else begin
      idle_d = idle_q + CNT_W'(1);
    end
  end

  assign cmd_addr_o    = addr_q;
  assign cmd_data_o    = data_q;
  assign cmd_valid_o   = valid_q;
  assign busy_o        = (state_q != IDLE);
  assign timeout_cnt_o = to_cnt_q;
`ifdef CMD_CHECKSUM_EN
  assign csum_err_cnt_o = cerr_q;
`else
  assign csum_err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_command_packetizer.sv
// Bench for command_packetizer: frame-level reference model compared every cycle, plus literal checks.
module tb_command_packetizer;

  localparam int TO = 16;
`ifdef CMD_CHECKSUM_EN
  localparam int FLEN    = 7;
  localparam bit CSUM_ON = 1'b1;
`else
  localparam int FLEN    = 6;
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        bv;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        busy;
  logic [7:0]  cerr_cnt;
  logic [7:0]  to_cnt;

  always #5 clk = ~clk;

  command_packetizer #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .byte_i         (byte_in),
    .byte_valid_i   (bv),
    .cmd_addr_o     (cmd_addr),
    .cmd_data_o     (cmd_data),
    .cmd_valid_o    (cmd_valid),
    .busy_o         (busy),
    .csum_err_cnt_o (cerr_cnt),
    .timeout_cnt_o  (to_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collects the bytes of the current frame and judges it once complete.
  logic [7:0]  fb[$];
  bit          in_frame = 1'b0;
  int          gap      = 0;
  logic [15:0] m_addr   = '0;
  logic [31:0] m_data   = '0;
  bit          m_valid  = 1'b0;
  int          m_cerr   = 0;
  int          m_to     = 0;
  int          cyc      = 0;
  bit          started  = 1'b0;
  logic [7:0]  m_x;

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    m_valid = 1'b0;
    if (rst) begin
      in_frame = 1'b0;
      fb.delete();
      gap    = 0;
      m_addr = '0;
      m_data = '0;
      m_cerr = 0;
      m_to   = 0;
    end else if (!in_frame) begin
      if (bv && byte_in == 8'hA5) begin
        in_frame = 1'b1;
        fb.delete();
        gap = 0;
      end
    end else if (bv) begin
      fb.push_back(byte_in);
      gap = 0;
      if (fb.size() == FLEN) begin
        m_x = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4] ^ fb[5];
        if (!CSUM_ON || m_x == fb[FLEN-1]) begin
          m_addr  = {fb[0], fb[1]};
          m_data  = {fb[2], fb[3], fb[4], fb[5]};
          m_valid = 1'b1;
        end else if (m_cerr < 255) begin
          m_cerr++;
        end
        in_frame = 1'b0;
      end
    end else begin
      gap++;
      if (gap == TO) begin
        in_frame = 1'b0;
        if (m_to < 255) m_to++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_valid", cmd_valid, m_valid);
      chk("cyc_addr",  cmd_addr,  m_addr);
      chk("cyc_data",  cmd_data,  m_data);
      chk("cyc_busy",  busy,      in_frame);
      chk("cyc_cerr",  cerr_cnt,  m_cerr);
      chk("cyc_tocnt", to_cnt,    m_to);
    end
  end

  // Strobe log used by the literal checks.
  int          s_cyc[$];
  logic [15:0] s_addr[$];
  logic [31:0] s_data[$];
  always @(posedge clk) begin
    #1;
    if (cmd_valid === 1'b1) begin
      s_cyc.push_back(cyc);
      s_addr.push_back(cmd_addr);
      s_data.push_back(cmd_data);
    end
  end

  task automatic drv(input logic v, input logic [7:0] bb);
    bv      = v;
    byte_in = bb;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 8'($urandom));
  endtask

  task automatic send_bytes(input logic [63:0] s, input int n);
    for (int i = 0; i < n; i++) drv(1'b1, s[8*(n-1-i) +: 8]);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [31:0] d, input bit bad);
    logic [7:0] x;
    x = a[15:8] ^ a[7:0] ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    if (bad) x = x ^ 8'h5A;
    send_bytes({8'hA5, a, d, x}, 8);
  endtask

  task automatic chk_strobe(input string nm, input int n0, input logic [15:0] ea, input logic [31:0] ed);
    chk({nm, "_count"}, s_addr.size() - n0, 1);
    if (s_addr.size() == n0 + 1) begin
      chk({nm, "_addr"}, s_addr[n0], ea);
      chk({nm, "_data"}, s_data[n0], ed);
    end
  endtask

  int n0;

  initial begin
    rst = 1'b1; bv = 1'b0; byte_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", cmd_valid, 0);
    chk("reset_addr",  cmd_addr,  0);
    chk("reset_busy",  busy,      0);
    chk("reset_tocnt", to_cnt,    0);

    n0 = s_addr.size();
    send_bytes(64'hA5_00_60_00_00_01_2C_4D, 8);
    idle(2);
    chk_strobe("good", n0, 16'h0060, 32'h0000_012C);
    chk("good_cerr", cerr_cnt, 0);

    n0 = s_addr.size();
    send_bytes(64'hA5_00_50_00_00_00_10_00, 8);
    idle(2);
`ifdef CMD_CHECKSUM_EN
    chk("bad_count", s_addr.size() - n0, 0);
    chk("bad_cerr",  cerr_cnt, 1);
    chk("bad_addr_hold", cmd_addr, 16'h0060);
    chk("bad_data_hold", cmd_data, 32'h0000_012C);
`else
    chk_strobe("nocsum", n0, 16'h0050, 32'h0000_0010);
    chk("nocsum_cerr", cerr_cnt, 0);
`endif

    n0 = s_addr.size();
    send_bytes(64'h11_22, 2);
    send_bytes(64'hA5_00_A5_00_00_00_01_A4, 8);
    idle(2);
    chk_strobe("garbage", n0, 16'h00A5, 32'h0000_0001);

    send_bytes(64'hA5_00, 2);
    idle(15);
    chk("to_busy_before", busy, 1);
    idle(1);
    chk("to_busy_after", busy, 0);
    chk("to_count", to_cnt, 1);

    n0 = s_addr.size();
    send_bytes(64'hA5_00, 2);
    idle(15);
    drv(1'b1, 8'h60);
    chk("noabort_busy", busy, 1);
    send_bytes(64'h00_00_01_2C_4D, 5);
    idle(2);
    chk("noabort_tocnt", to_cnt, 1);
    chk_strobe("noabort", n0, 16'h0060, 32'h0000_012C);

    n0 = s_addr.size();
    send_frame(16'h1234, 32'hDEAD_BEEF, 1'b0);
    send_frame(16'hABCD, 32'h0102_0304, 1'b0);
    idle(2);
    chk("b2b_count", s_addr.size() - n0, 2);
    if (s_addr.size() == n0 + 2) begin
      chk("b2b_gap",   s_cyc[n0+1] - s_cyc[n0], 8);
      chk("b2b_addr1", s_addr[n0],   16'h1234);
      chk("b2b_addr2", s_addr[n0+1], 16'hABCD);
      chk("b2b_data2", s_data[n0+1], 32'h0102_0304);
    end

    n0 = s_addr.size();
    send_bytes(64'hA5_00_10, 3);
    rst = 1'b1;
    drv(1'b0, 8'h00);
    rst = 1'b0;
    chk("midrst_addr",  cmd_addr, 0);
    chk("midrst_data",  cmd_data, 0);
    chk("midrst_busy",  busy,     0);
    chk("midrst_tocnt", to_cnt,   0);
    chk("midrst_count", s_addr.size() - n0, 0);
    send_bytes(64'hA5_00_60_00_00_01_2C_4D, 8);
    idle(2);
    chk_strobe("after_rst", n0, 16'h0060, 32'h0000_012C);

    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 5))
        0, 1: send_frame(16'($urandom), $urandom, $urandom_range(0, 3) == 0);
        2: repeat ($urandom_range(1, 6))
             drv(1'b1, ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom));
        3: idle($urandom_range(1, 20));
        4: begin
          drv(1'b1, 8'hA5);
          repeat ($urandom_range(1, 5)) drv(1'b1, 8'($urandom));
          idle($urandom_range(10, 20));
        end
        default: begin
          drv(1'b1, 8'hA5);
          repeat (7) begin
            idle($urandom_range(0, 1) == 0 ? 0 : $urandom_range(13, 17));
            drv(1'b1, 8'($urandom));
          end
        end
      endcase
    end

    rst = 1'b1;
    drv(1'b0, 8'h00);
    rst = 1'b0;
    repeat (260) send_frame(16'h0102, 32'h0304_0506, 1'b1);
    repeat (260) begin
      drv(1'b1, 8'hA5);
      idle(TO + 1);
    end
    chk("sat_cerr", cerr_cnt, CSUM_ON ? 255 : 0);
    chk("sat_tocnt", to_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
